// File: rtl/gradient_descent_top.sv
// gradient_descent_top: fixed-point (Q24.8) gradient descent on (x - OFFSET)^2 with saturating arithmetic.
// Define GD_OVERFLOW_FLAGS_EN to build the four overflow flags; otherwise they are tied to 0.
module gradient_descent_top #(
    parameter int unsigned        NUM_ITERATIONS = 5,
    parameter logic signed [31:0] OFFSET         = 32'sh00000400,
    parameter logic signed [31:0] LEARNING_RATE  = 32'sh00000080
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_op,
    input  logic signed [31:0] initial_x_in,
    output logic signed [31:0] x_at_min,
    output logic signed [55:0] y_min,
    output logic               done_op,
    output logic signed [31:0] learning_rate_out,
    output logic               gradient_overflow,
    output logic               x_sqr_overflow,
    output logic               x_diff_overflow,
    output logic               init_x_square_overflow
);
    typedef enum logic [2:0] {IDLE, LOAD, GRAD, UPDATE, EVAL, DONE} state_t;

    localparam logic signed [63:0] MAX32 = 64'sh000000007FFFFFFF;
    localparam logic signed [63:0] MIN32 = -64'sh0000000080000000;

    function automatic logic ovf32(input logic signed [63:0] v);
        return (v > MAX32) || (v < MIN32);
    endfunction

    function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
        return (v > MAX32) ? 32'sh7FFFFFFF : (v < MIN32) ? 32'sh80000000 : v[31:0];
    endfunction

    state_t             r_state;
    logic signed [31:0] r_x;
    logic signed [31:0] r_grad;
    logic signed [31:0] r_x_at_min;
    logic signed [55:0] r_y_min;
    logic [31:0]        r_cnt;
    logic               r_done;

    logic signed [63:0] w_diff_full;
    logic signed [63:0] w_grad_full;
    logic signed [63:0] w_prod;
    logic signed [63:0] w_xnew_full;
    logic signed [63:0] w_sq;
    logic signed [31:0] w_diff;
    logic signed [31:0] w_step;
    logic signed [31:0] w_xnew;
    logic signed [55:0] w_y;
    logic [31:0]        w_cnt_next;

    // All intermediate arithmetic is carried at 64 bits so saturation sees the true value.
    always_comb begin
        w_diff_full = r_x - OFFSET;
        w_diff      = sat32(w_diff_full);
        w_grad_full = {{31{w_diff[31]}}, w_diff, 1'b0};
        w_prod      = r_grad * LEARNING_RATE;
        w_step      = sat32(w_prod >>> 8);
        w_xnew_full = r_x - w_step;
        w_xnew      = sat32(w_xnew_full);
        w_sq        = w_diff * w_diff;
        w_y         = 56'(w_sq >>> 8);
        w_cnt_next  = r_cnt + 32'd1;
    end

`ifdef GD_OVERFLOW_FLAGS_EN
    logic               r_grad_ovf;
    logic               r_sqr_ovf;
    logic               r_diff_ovf;
    logic               r_init_ovf;
    logic signed [63:0] w_init_sq;

    assign w_init_sq              = initial_x_in * initial_x_in;
    assign gradient_overflow      = r_grad_ovf;
    assign x_sqr_overflow         = r_sqr_ovf;
    assign x_diff_overflow        = r_diff_ovf;
    assign init_x_square_overflow = r_init_ovf;
`else
    assign gradient_overflow      = 1'b0;
    assign x_sqr_overflow         = 1'b0;
    assign x_diff_overflow        = 1'b0;
    assign init_x_square_overflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_x        <= '0;
            r_grad     <= '0;
            r_x_at_min <= '0;
            r_y_min    <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
`ifdef GD_OVERFLOW_FLAGS_EN
            r_grad_ovf <= 1'b0;
            r_sqr_ovf  <= 1'b0;
            r_diff_ovf <= 1'b0;
            r_init_ovf <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (start_op) r_state <= LOAD;
                LOAD: begin
                    r_x     <= initial_x_in;
                    r_cnt   <= '0;
                    r_state <= (NUM_ITERATIONS != 0) ? GRAD : EVAL;
`ifdef GD_OVERFLOW_FLAGS_EN
                    r_grad_ovf <= 1'b0;
                    r_sqr_ovf  <= 1'b0;
                    r_diff_ovf <= 1'b0;
                    r_init_ovf <= (w_init_sq >>> 8) > MAX32;
`endif
                end
                GRAD: begin
                    r_grad  <= sat32(w_grad_full);
                    r_state <= UPDATE;
`ifdef GD_OVERFLOW_FLAGS_EN
                    r_grad_ovf <= r_grad_ovf | ovf32(w_grad_full);
                    r_diff_ovf <= r_diff_ovf | ovf32(w_diff_full);
`endif
                end
                UPDATE: begin
                    r_x     <= w_xnew;
                    r_cnt   <= w_cnt_next;
                    r_state <= (w_cnt_next < NUM_ITERATIONS) ? GRAD : EVAL;
                end
                EVAL: begin
                    r_x_at_min <= r_x;
                    r_y_min    <= w_y;
                    r_state    <= DONE;
`ifdef GD_OVERFLOW_FLAGS_EN
                    r_sqr_ovf  <= w_y > MAX32;
                    r_diff_ovf <= r_diff_ovf | ovf32(w_diff_full);
`endif
                end
                // done_op is registered: it rises one cycle into DONE, then waits for start_op to drop.
                DONE: begin
                    if (!r_done) begin
                        r_done <= 1'b1;
                    end else if (!start_op) begin
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign x_at_min          = r_x_at_min;
    assign y_min             = r_y_min;
    assign done_op           = r_done;
    assign learning_rate_out = LEARNING_RATE;
endmodule

// File: tb/tb_gradient_descent_top.sv
// tb_gradient_descent_top: scoreboard bench comparing two gradient_descent_top builds against an iterative reference model.
module tb_gradient_descent_top;
    localparam longint OFF  = 1024;
    localparam longint MAXV = 2147483647;
    localparam longint MINV = -MAXV - 1;
`ifdef GD_OVERFLOW_FLAGS_EN
    localparam bit [3:0] FLAG_MASK = 4'hF;
`else
    localparam bit [3:0] FLAG_MASK = 4'h0;
`endif

    typedef struct {
        longint   x;
        longint   y;
        longint   t;
        bit [3:0] f;
    } res_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_a = 1'b0;
    logic               start_b = 1'b0;
    logic signed [31:0] x_in_a = '0;
    logic signed [31:0] x_in_b = '0;
    logic signed [31:0] x_a, x_b, lr_a, lr_b;
    logic signed [55:0] y_a, y_b;
    logic               done_a, done_b;
    logic               gov_a, sqov_a, dov_a, iov_a;
    logic               gov_b, sqov_b, dov_b, iov_b;
    logic               prev_a = 1'b0;
    logic               prev_b = 1'b0;
    int                 n_checks = 0;
    int                 n_fail = 0;
    longint             cyc = 0;
    res_t               q_a[$];
    res_t               q_b[$];

    gradient_descent_top dut_a (
        .clk(clk), .rst(rst), .start_op(start_a), .initial_x_in(x_in_a),
        .x_at_min(x_a), .y_min(y_a), .done_op(done_a), .learning_rate_out(lr_a),
        .gradient_overflow(gov_a), .x_sqr_overflow(sqov_a), .x_diff_overflow(dov_a),
        .init_x_square_overflow(iov_a)
    );

    gradient_descent_top #(.NUM_ITERATIONS(1), .LEARNING_RATE(32'sh40)) dut_b (
        .clk(clk), .rst(rst), .start_op(start_b), .initial_x_in(x_in_b),
        .x_at_min(x_b), .y_min(y_b), .done_op(done_b), .learning_rate_out(lr_b),
        .gradient_overflow(gov_b), .x_sqr_overflow(sqov_b), .x_diff_overflow(dov_b),
        .init_x_square_overflow(iov_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint sat(input longint v);
        return (v > MAXV) ? MAXV : (v < MINV) ? MINV : v;
    endfunction

    // Reference: run the descent loop directly on 64-bit integers, clamping each step.
    function automatic res_t model(input longint x0, input int n, input longint lr, input longint t);
        res_t   r;
        longint x = x0;
        longint d, g;
        bit     go = 0, dov = 0, iov, sqo;
        for (int i = 0; i < n; i++) begin
            d = x - OFF;
            dov |= (d != sat(d));
            d = sat(d);
            g = 2 * d;
            go |= (g != sat(g));
            g = sat(g);
            x = sat(x - sat((g * lr) >>> 8));
        end
        d = x - OFF;
        dov |= (d != sat(d));
        d = sat(d);
        r.x = x;
        r.y = (d * d) >>> 8;
        r.t = t;
        iov = ((x0 * x0) >>> 8) > MAXV;
        sqo = r.y > MAXV;
        r.f = {go, sqo, dov, iov} & FLAG_MASK;
        return r;
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic compare(input string tag, input res_t e, input longint x, input longint y, input bit [3:0] f);
        check({tag, " x_at_min"}, x, e.x);
        check({tag, " y_min"}, y, e.y);
        check({tag, " flags"}, longint'(f), longint'(e.f));
        check({tag, " latency"}, cyc, e.t);
    endtask

    always @(negedge clk) begin
        if (!rst && done_a && !prev_a) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done_a: got done with empty queue");
            end else begin
                compare("a", q_a.pop_front(), x_a, y_a, {gov_a, sqov_a, dov_a, iov_a});
            end
        end
        prev_a <= done_a;
    end

    always @(negedge clk) begin
        if (!rst && done_b && !prev_b) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done_b: got done with empty queue");
            end else begin
                compare("b", q_b.pop_front(), x_b, y_b, {gov_b, sqov_b, dov_b, iov_b});
            end
        end
        prev_b <= done_b;
    end

    task automatic run_a(input logic signed [31:0] x0, input int hold);
        @(negedge clk);
        x_in_a  = x0;
        start_a = 1'b1;
        q_a.push_back(model(longint'(x0), 5, 128, cyc + 1 + 13));
        for (int i = 0; i < 60 && !done_a; i++) @(negedge clk);
        if (!done_a) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_a: got done_op=0 expected 1");
        end
        repeat (hold) begin
            @(negedge clk);
            check("hold_done_a", done_a, 1);
        end
        start_a = 1'b0;
        @(posedge clk);
        #1 check("done_fall_a", done_a, 0);
        @(negedge clk);
    endtask

    task automatic run_b(input logic signed [31:0] x0);
        @(negedge clk);
        x_in_b  = x0;
        start_b = 1'b1;
        q_b.push_back(model(longint'(x0), 1, 64, cyc + 1 + 5));
        for (int i = 0; i < 30 && !done_b; i++) @(negedge clk);
        if (!done_b) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_b: got done_op=0 expected 1");
        end
        start_b = 1'b0;
        @(posedge clk);
        #1 check("done_fall_b", done_b, 0);
        @(negedge clk);
    endtask

    task automatic check_reset_state();
        check("rst x_at_min", x_a, 0);
        check("rst y_min", y_a, 0);
        check("rst done_op", done_a, 0);
        check("rst flags", longint'({gov_a, sqov_a, dov_a, iov_a}), 0);
        check("rst done_b", done_b, 0);
        check("rst learning_rate_out", lr_a, 128);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state();
        rst = 1'b0;

        run_a(32'sh400003F8, 3);
        run_a(32'sh40000401, 0);
        run_a(32'sh00000000, 1);
        check("learning_rate_out", lr_a, 128);
        run_a(32'sh80000000, 2);
        run_a(32'sh7FFFFFFF, 0);
        run_b(32'sh00000800);
        check("learning_rate_out_b", lr_b, 64);

        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) run_a($signed($urandom), int'($urandom_range(0, 3)));
            else            run_a(32'sh400 + $signed(32'($urandom_range(0, 4095))) - 32'sh800, 0);
        end
        for (int i = 0; i < 6; i++) run_b($signed($urandom));

        // Abort a run with reset part-way through, then show a clean run still works.
        @(negedge clk);
        x_in_a  = $signed($urandom);
        start_a = 1'b1;
        repeat (6) @(negedge clk);
        rst     = 1'b1;
        start_a = 1'b0;
        @(posedge clk);
        #1 check_reset_state();
        @(negedge clk);
        rst = 1'b0;
        run_a(32'sh00001234, 1);

        repeat (3) @(negedge clk);
        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
